// File: rtl/pe_conv_row.sv
// pe_conv_row: weight-stationary 5-tap 1D convolution PE; one ifmap row becomes 21 psum NOC flits.
module pe_conv_row #(
  parameter logic [3:0] PE_ADDR    = 4'b0000,
  parameter logic [3:0] PSUM_DEST  = 4'b0000,
  parameter int         PSUM_WIDTH = 12,
  parameter int         ROW_WRAP   = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        row_done,
  output logic [7:0]  drop_cnt
);
  typedef enum logic {IDLE, COMPUTE} state_t;
  state_t          state_q, state_d;
  logic [4:0][7:0] w_q, w_d;
  logic            w_loaded_q, w_loaded_d;
  logic [24:0]     s_q, s_d;
  logic [4:0]      k_q, k_d, tag_q, tag_d;
  logic            out_valid_q, out_valid_d, row_done_q, row_done_d;
  logic [63:0]     out_data_q, out_data_d;
  logic [7:0]      drop_q, drop_d;
  logic            accept, dst_ok;
  logic [1:0]      typ;
  logic            unused_bits;
  // Spike window of five columns starting at k gates the stationary weights.
  function automatic logic [63:0] flit(logic [4:0][7:0] w, logic [24:0] s, logic [4:0] tag, logic [4:0] k);
    logic [4:0]  win;
    logic [10:0] sum;
    win = 5'(s >> k);
    sum = '0;
    for (int j = 0; j < 5; j++) sum = sum + (win[j] ? 11'(w[j]) : 11'd0);
    return {PE_ADDR, PSUM_DEST, 2'b10, 32'd0, tag, k, 12'(PSUM_WIDTH'(sum))};
  endfunction
  assign in_ready    = (state_q == IDLE) & rst_n;
  assign accept      = in_valid & in_ready;
  assign dst_ok      = in_data[59:56] == PE_ADDR;
  assign typ         = in_data[55:54];
  assign unused_bits = ^{in_data[63:60], in_data[53:40]};
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign row_done    = row_done_q;
  assign drop_cnt    = drop_q;
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    w_loaded_d  = w_loaded_q;
    s_d         = s_q;
    k_d         = k_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    drop_d      = drop_q;
    row_done_d  = 1'b0;
    if (state_q == IDLE && accept) begin
      if (dst_ok && typ == 2'b01) begin
        w_d        = in_data[39:0];
        w_loaded_d = 1'b1;
      end else if (dst_ok && typ == 2'b00 && w_loaded_q) begin
        s_d         = in_data[24:0];
        k_d         = '0;
        out_valid_d = 1'b1;
        out_data_d  = flit(w_q, in_data[24:0], tag_q, 5'd0);
        state_d     = COMPUTE;
      end else begin
        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      end
    end else if (state_q == COMPUTE && out_valid_q && out_ready) begin
      if (k_q != 5'd20) begin
        k_d        = k_q + 5'd1;
        out_data_d = flit(w_q, s_q, tag_q, k_q + 5'd1);
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        row_done_d  = 1'b1;
        tag_d       = (tag_q == 5'(ROW_WRAP - 1)) ? 5'd0 : tag_q + 5'd1;
        state_d     = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      w_loaded_q  <= 1'b0;
      s_q         <= '0;
      k_q         <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      row_done_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      w_loaded_q  <= w_loaded_d;
      s_q         <= s_d;
      k_q         <= k_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      row_done_q  <= row_done_d;
      drop_q      <= drop_d;
    end
  end
endmodule

// File: tb/tb_pe_conv_row.sv
// tb_pe_conv_row: directed and randomized checks of pe_conv_row against an arithmetic convolution model.
module tb_pe_conv_row;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        row_done;
  logic [7:0]  drop_cnt;
  int checks = 0;
  int failures = 0;
  int mw[5];
  int mtag = 0;
  int mdrop = 0;
  int cyc_used;
  pe_conv_row dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .row_done(row_done), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model_flit(input logic [24:0] row, input int k, input int tag);
    int p = 0;
    for (int j = 0; j < 5; j++) if (row[k + j]) p += mw[j];
    return {4'h0, 4'h0, 2'b10, 32'd0, 5'(tag), 5'(k), 12'(p)};
  endfunction
  function automatic logic [63:0] kernel_flit(input logic [3:0] dst, input int a, input int b, input int c, input int d, input int e);
    logic [13:0] junk = 14'($urandom);
    return {4'h7, dst, 2'b01, junk, 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic logic [63:0] ifmap_flit(input logic [3:0] dst, input logic [24:0] row);
    logic [28:0] junk = 29'($urandom);
    return {4'h3, dst, 2'b00, junk, row};
  endfunction
  task automatic send(input logic [63:0] f);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("send_in_ready", {63'd0, in_ready}, 64'd1);
    in_data = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic load_kernel(input int a, input int b, input int c, input int d, input int e);
    send(kernel_flit(4'h0, a, b, c, d, e));
    mw[0] = a; mw[1] = b; mw[2] = c; mw[3] = d; mw[4] = e;
    check("kernel_no_output", {63'd0, out_valid}, 64'd0);
  endtask
  task automatic drop_one(input string tag, input logic [63:0] f);
    send(f);
    mdrop = (mdrop == 255) ? 255 : mdrop + 1;
    check({tag, "_drop_cnt"}, {56'd0, drop_cnt}, 64'(mdrop));
    check({tag, "_no_output"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask
  // Sends one ifmap row and drains its 21 flits; ready_pct sets the out_ready duty.
  task automatic run_row(input logic [24:0] row, input int ready_pct);
    int n = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [63:0] held = '0;
    send(ifmap_flit(4'h0, row));
    while (n < 21 && cyc < 400) begin
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      if (stalled) check("stall_stable", out_data, held);
      check("busy_in_ready", {63'd0, in_ready}, 64'd0);
      check("row_out_valid", {63'd0, out_valid}, 64'd1);
      if (out_valid && out_ready) begin
        check($sformatf("flit_k%0d", n), out_data, model_flit(row, n, mtag));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data;
      end
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
    cyc_used = cyc;
    check("row_flit_count", 64'(n), 64'd21);
    check("row_done_pulse", {63'd0, row_done}, 64'd1);
    check("row_end_valid", {63'd0, out_valid}, 64'd0);
    mtag = (mtag == 24) ? 0 : mtag + 1;
    @(posedge clk); #1;
    check("row_done_clear", {63'd0, row_done}, 64'd0);
    check("row_end_in_ready", {63'd0, in_ready}, 64'd1);
  endtask
  initial begin
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_row_done", {63'd0, row_done}, 64'd0);
    check("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    drop_one("ifmap_no_weights", ifmap_flit(4'h0, 25'h1FFFFFF));
    drop_one("kernel_wrong_dst", kernel_flit(4'h5, 9, 9, 9, 9, 9));
    drop_one("ifmap_still_no_weights", ifmap_flit(4'h0, 25'h1FFFFFF));
    drop_one("type10", {4'h0, 4'h0, 2'b10, 54'h12345});
    drop_one("type11", {4'h0, 4'h0, 2'b11, 54'h0});
    load_kernel(1, 1, 1, 1, 1);
    drop_one("ifmap_wrong_dst", ifmap_flit(4'h9, 25'h1FFFFFF));
    run_row(25'h1FFFFFF, 100);
    check("full_throughput_cycles", 64'(cyc_used), 64'd21);
    load_kernel(1, 2, 3, 4, 5);
    run_row(25'h0000010, 100);
    load_kernel(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_row(25'h1FFFFFF, 100);
    check("max_psum_cycles", 64'(cyc_used), 64'd21);
    for (int r = 0; r < 26; r++) begin
      if (r % 4 == 0) load_kernel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                                  $urandom_range(0, 255), $urandom_range(0, 255));
      run_row(25'($urandom), 50);
    end
    load_kernel(3, 1, 4, 1, 5);
    send(ifmap_flit(4'h0, 25'h0ABCDEF));
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_k8", out_data, model_flit(25'h0ABCDEF, 8, mtag));
    rst_n = 1'b0;
    #1;
    check("midrow_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrow_rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    check("midrow_rst_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    mdrop = 0;
    mtag = 0;
    @(posedge clk); #1;
    check("post_rst_no_output", {63'd0, out_valid}, 64'd0);
    drop_one("post_rst_ifmap", ifmap_flit(4'h0, 25'h1FFFFFF));
    load_kernel(2, 0, 7, 1, 6);
    run_row(25'($urandom), 70);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
